ysyx_040066_store_align: RTL and testbench
==========================================

# ysyx_040066_store_align

Store-side counterpart of the write-back load extractor. It takes a store from the memory stage (`MemOp`, address, `rs2` data), places the data in the correct byte lanes of a 64-bit bus word, and builds the byte write mask. It drives a single-outstanding request/acknowledge write port to the data memory, stalling the pipeline until the write completes, times out, or errors. Lane selection uses the same truncating rule as the load path, so a load that follows a store to the same address returns the stored value.

## Interface
- `TIMEOUT`, default 255: maximum number of BUSY cycles to wait for `mem_ack`; 0 disables the timeout.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  the memory-stage instruction is valid.
- `MemWr_in`  in  1  the instruction is a store.
- `MemOp_in`  in  3  store size in [1:0]: 00 byte, 01 half, 10 word, 11 dword; bit 2 is ignored.
- `addr_in`  in  64  effective store address.
- `data_in`  in  64  store data; the value sits in the low bits.
- `flush`  in  1  squashes the store presented this cycle.
- `mem_req`  out  1  write request.
- `mem_addr`  out  64  `addr & ~64'h7`.
- `mem_wdata`  out  64  lane-aligned write data.
- `mem_wmask`  out  8  byte enables; bit i covers `wdata[8i+7:8i]`.
- `mem_ack`  in  1  write accepted or completed.
- `mem_err`  in  1  bus error; qualified by `mem_ack`.
- `block_out`  out  1  pipeline stall.
- `done`  out  1  one-cycle completion pulse.
- `error_out`  out  1  error status; meaningful only while `done`=1.

## Operation
- States: IDLE, BUSY, DONE.
- Accept condition: state is IDLE or DONE, and `valid_in & MemWr_in & ~flush`. On accept:
  - register `mem_addr`, `mem_wdata` and `mem_wmask`;
  - clear the timeout counter;
  - go to BUSY.
- Lane rules (`a = addr_in[2:0]`; unused lanes of `mem_wdata` are 0):
  - byte: `wdata = data[7:0] << 8*a`, `wmask = 8'h01 << a`.
  - half: lane index `a[2:1]`, so `a[0]` is ignored; `wdata = data[15:0] << 16*a[2:1]`, `wmask = 8'h03 << 2*a[2:1]`.
  - word: `a[1:0]` is ignored; `wdata = data[31:0] << 32*a[2]`, `wmask = 8'h0F << 4*a[2]`.
  - dword: `wdata = data`, `wmask = 8'hFF`.
- No store is treated as misaligned; truncation is the defined behaviour.
- BUSY:
  - `mem_req`=1 and the address, data and mask are held stable.
  - `mem_ack`=1 → DONE, with the error flag set to `mem_err`.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT` and `TIMEOUT`≠0 → DONE with the error flag set to 1.
- DONE:
  - `done`=1 and `error_out` shows the error flag.
  - With a new accept → BUSY; otherwise → IDLE.
- `block_out` = (state == BUSY). DONE does not stall, so back-to-back stores are possible.
- `flush` only prevents acceptance. A store already in BUSY always completes; it is never cancelled.
- Non-store or invalid inputs in IDLE or DONE have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE;
  - `mem_req`, `done`, `error_out`, `block_out` = 0;
  - `mem_addr`, `mem_wdata`, `mem_wmask` = 0;
  - counter = 0.
- Reset asserted mid-BUSY drops `mem_req` at once. The write may be lost; that is acceptable.
- Accept at edge N: `mem_req`=1 and `block_out`=1 during cycle N+1.
- `mem_ack` sampled high at edge M: `mem_req`=0 and `done`=1 during cycle M+1.
- Minimum store latency is 2 cycles (`ack` in the first BUSY cycle).
- `mem_ack` while not in BUSY is ignored.
- `mem_err` without `mem_ack` is ignored.
- Timeout: with no `ack`, DONE is entered after exactly `TIMEOUT` BUSY cycles, and `mem_req` falls in the same cycle `done` rises.
- `mem_ack` on the same edge the timeout expires: the `ack` wins, and the error flag takes `mem_err`.
- Accept in DONE: during the next cycle `done`=0 and `mem_req`=1.
- Outputs are registered; nothing combinational runs from `mem_ack` to `mem_req`.

## Test plan
- Byte store, `addr=0x8000_0005`, `data=0x..AB`, `ack` in the first BUSY cycle:
  - `mem_addr=0x8000_0000`, `wmask=0x20`, `wdata=0x0000_AB00_0000_0000`;
  - `done` 2 cycles after accept, `error_out=0`.
- Half at `a=3`, word at `a=6`, dword at `a=0`, with `data=0x1122_3344_5566_7788`:
  - half: `wmask=0x0C`, `wdata=0x0000_0000_7788_0000`;
  - word: `wmask=0xF0`, `wdata=0x5566_7788_0000_0000`;
  - dword: `wmask=0xFF`, `wdata=data`.
- `ack` delayed 5 cycles:
  - `mem_req` and `block_out` high for 6 cycles with outputs stable;
  - changing `data_in` or `flush` during BUSY has no effect.
- `TIMEOUT=4` with no `ack`:
  - `done=1`, `error_out=1` after 4 BUSY cycles;
  - a later `ack` is ignored.
- `mem_ack=1` with `mem_err=1` → `done=1`, `error_out=1`.
- Sequence checks:
  - a second store presented during the DONE cycle is accepted, and `mem_req` rises on the next cycle;
  - `flush` on a store in IDLE → no request is issued;
  - `rst_n` low mid-BUSY → all outputs are 0 immediately.

Source files
------------

// File: rtl/ysyx_040066_store_align.sv
// Store aligner: places store data in the right byte lanes of a 64-bit bus word,
// builds the byte mask and runs a single-outstanding req/ack write with timeout.
module ysyx_040066_store_align #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        MemWr_in,
    input  logic [2:0]  MemOp_in,
    input  logic [63:0] addr_in,
    input  logic [63:0] data_in,
    input  logic        flush,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic        mem_err,
    output logic        block_out,
    output logic        done,
    output logic        error_out
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               mem_req_q, mem_req_d;
    logic               block_q, block_d;
    logic               done_q, done_d;
    logic               error_out_q, error_out_d;
    logic [63:0]        mem_addr_q, mem_addr_d;
    logic [63:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]         mem_wmask_q, mem_wmask_d;

    logic [2:0]         lane;
    logic [63:0]        lane_wdata;
    logic [7:0]         lane_wmask;
    logic               accept;

    // Lane placement; offsets below the access size are truncated, matching the load path.
    always_comb begin
        lane       = addr_in[2:0];
        lane_wdata = 64'h0;
        lane_wmask = 8'h00;
        unique case (MemOp_in[1:0])
            2'b00: begin
                lane_wdata = 64'(data_in[7:0]) << {lane, 3'b000};
                lane_wmask = 8'h01 << lane;
            end
            2'b01: begin
                lane_wdata = 64'(data_in[15:0]) << {lane[2:1], 4'b0000};
                lane_wmask = 8'h03 << {lane[2:1], 1'b0};
            end
            2'b10: begin
                lane_wdata = 64'(data_in[31:0]) << {lane[2], 5'b00000};
                lane_wmask = 8'h0F << {lane[2], 2'b00};
            end
            default: begin
                lane_wdata = data_in;
                lane_wmask = 8'hFF;
            end
        endcase
    end

    // Next state and registered-output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        accept      = valid_in & MemWr_in & ~flush;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d     = ST_BUSY;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    mem_addr_d  = {addr_in[63:3], 3'b000};
                    mem_wdata_d = lane_wdata;
                    mem_wmask_d = lane_wmask;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    err_d   = mem_err;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mem_req_d   = (state_d == ST_BUSY);
        block_d     = (state_d == ST_BUSY);
        done_d      = (state_d == ST_DONE);
        error_out_d = (state_d == ST_DONE) & err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            block_q     <= 1'b0;
            done_q      <= 1'b0;
            error_out_q <= 1'b0;
            mem_addr_q  <= 64'h0;
            mem_wdata_q <= 64'h0;
            mem_wmask_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            block_q     <= block_d;
            done_q      <= done_d;
            error_out_q <= error_out_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign block_out = block_q;
    assign done      = done_q;
    assign error_out = error_out_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_ysyx_040066_store_align.sv
// Directed bench for the store aligner: lane placement, handshake timing,
// timeout, error reporting, flush and asynchronous reset.
module tb_ysyx_040066_store_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, valid_t, MemWr_in, flush, ack, ack_t, err;
    logic [2:0]  MemOp_in;
    logic [63:0] addr_in, data_in;

    logic        req, blk, dn, eo;
    logic [63:0] maddr, wdata;
    logic [7:0]  wmask;
    logic        t_req, t_blk, t_dn, t_eo;
    logic [63:0] t_maddr, t_wdata;
    logic [7:0]  t_wmask;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] D = 64'h1122_3344_5566_7788;

    always #5 clk = ~clk;

    ysyx_040066_store_align dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .MemWr_in(MemWr_in),
        .MemOp_in(MemOp_in), .addr_in(addr_in), .data_in(data_in), .flush(flush),
        .mem_req(req), .mem_addr(maddr), .mem_wdata(wdata), .mem_wmask(wmask),
        .mem_ack(ack), .mem_err(err), .block_out(blk), .done(dn), .error_out(eo)
    );

    ysyx_040066_store_align #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_t), .MemWr_in(MemWr_in),
        .MemOp_in(MemOp_in), .addr_in(addr_in), .data_in(data_in), .flush(flush),
        .mem_req(t_req), .mem_addr(t_maddr), .mem_wdata(t_wdata), .mem_wmask(t_wmask),
        .mem_ack(ack_t), .mem_err(err), .block_out(t_blk), .done(t_dn), .error_out(t_eo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one store to the main DUT for a single edge.
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
        valid_in = 1'b1; MemWr_in = 1'b1; MemOp_in = op; addr_in = a; data_in = d;
        tick();
        valid_in = 1'b0; MemWr_in = 1'b0;
    endtask

    // Store with ack in the first BUSY cycle; checks placement and completion.
    task automatic quick_store(input string tag, input logic [2:0] op, input logic [63:0] a,
                               input logic [63:0] d, input logic [63:0] exp_addr,
                               input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
        issue(op, a, d);
        chk({tag, "_req"},   64'(req),   64'd1);
        chk({tag, "_blk"},   64'(blk),   64'd1);
        chk({tag, "_addr"},  maddr,      exp_addr);
        chk({tag, "_mask"},  64'(wmask), 64'(exp_mask));
        chk({tag, "_wdata"}, wdata,      exp_wdata);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_done"},  64'(dn),    64'd1);
        chk({tag, "_err"},   64'(eo),    64'd0);
        chk({tag, "_req0"},  64'(req),   64'd0);
        chk({tag, "_blk0"},  64'(blk),   64'd0);
        tick();
        chk({tag, "_idle"},  64'(dn),    64'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; valid_t = 1'b0; MemWr_in = 1'b0; flush = 1'b0;
        ack = 1'b0; ack_t = 1'b0; err = 1'b0; MemOp_in = 3'd0; addr_in = '0; data_in = '0;
        tick(); tick();
        chk("rst_req",  64'(req),   64'd0);
        chk("rst_blk",  64'(blk),   64'd0);
        chk("rst_done", 64'(dn),    64'd0);
        chk("rst_err",  64'(eo),    64'd0);
        chk("rst_addr", maddr,      64'd0);
        chk("rst_wd",   wdata,      64'd0);
        chk("rst_mask", 64'(wmask), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        quick_store("byte",  3'b000, 64'h8000_0005, 64'h1234_5678_9ABC_DEAB,
                    64'h8000_0000, 8'h20, 64'h0000_AB00_0000_0000);
        quick_store("half",  3'b101, 64'h0000_1003, D,
                    64'h0000_1000, 8'h0C, 64'h0000_0000_7788_0000);
        quick_store("word",  3'b010, 64'h0000_2006, D,
                    64'h0000_2000, 8'hF0, 64'h5566_7788_0000_0000);
        quick_store("dword", 3'b011, 64'h0000_3000, D,
                    64'h0000_3000, 8'hFF, D);

        // Ack after 6 BUSY cycles; inputs wiggle and unqualified mem_err must be ignored.
        issue(3'b001, 64'h0000_4002, 64'h0000_0000_0000_BEEF);
        for (int i = 0; i < 6; i++) begin
            chk("slow_req",   64'(req),   64'd1);
            chk("slow_blk",   64'(blk),   64'd1);
            chk("slow_done",  64'(dn),    64'd0);
            chk("slow_wdata", wdata,      64'h0000_0000_BEEF_0000);
            chk("slow_mask",  64'(wmask), 64'h0C);
            chk("slow_addr",  maddr,      64'h0000_4000);
            valid_in = 1'b1; MemWr_in = 1'b1; MemOp_in = 3'b011;
            data_in = 64'(i) * 64'h0101_0101; flush = i[0];
            err = ~i[0];
            if (i == 5) begin
                ack = 1'b1; err = 1'b0;
            end
            tick();
        end
        valid_in = 1'b0; MemWr_in = 1'b0; flush = 1'b0; ack = 1'b0; err = 1'b0;
        chk("slow_fin_done", 64'(dn),  64'd1);
        chk("slow_fin_err",  64'(eo),  64'd0);
        chk("slow_fin_req",  64'(req), 64'd0);
        tick();

        // Bus error reported with ack.
        issue(3'b000, 64'h10, 64'h5A);
        ack = 1'b1; err = 1'b1;
        tick();
        ack = 1'b0; err = 1'b0;
        chk("berr_done", 64'(dn), 64'd1);
        chk("berr_err",  64'(eo), 64'd1);
        tick();
        chk("berr_clr",  64'(eo), 64'd0);

        // Back-to-back: second store accepted in the DONE cycle.
        issue(3'b010, 64'h20, 64'hCAFE_F00D);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("b2b_done1", 64'(dn), 64'd1);
        valid_in = 1'b1; MemWr_in = 1'b1; MemOp_in = 3'b000; addr_in = 64'h27; data_in = 64'h99;
        tick();
        valid_in = 1'b0; MemWr_in = 1'b0;
        chk("b2b_done0", 64'(dn),    64'd0);
        chk("b2b_req",   64'(req),   64'd1);
        chk("b2b_mask",  64'(wmask), 64'h80);
        chk("b2b_wdata", wdata,      64'h9900_0000_0000_0000);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("b2b_done2", 64'(dn), 64'd1);
        tick();

        // Flushed store and non-store in IDLE issue nothing.
        valid_in = 1'b1; MemWr_in = 1'b1; flush = 1'b1; MemOp_in = 3'b011; addr_in = 64'h88;
        tick();
        chk("flush_req", 64'(req), 64'd0);
        chk("flush_blk", 64'(blk), 64'd0);
        flush = 1'b0; MemWr_in = 1'b0;
        tick();
        chk("load_req",  64'(req), 64'd0);
        valid_in = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack",  64'(dn), 64'd0);

        // Timeout with TIMEOUT=4, then a stray ack is ignored.
        valid_t = 1'b1; MemWr_in = 1'b1; MemOp_in = 3'b011; addr_in = 64'h100; data_in = D;
        tick();
        valid_t = 1'b0; MemWr_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req",  64'(t_req), 64'd1);
            chk("to_done", 64'(t_dn),  64'd0);
            tick();
        end
        chk("to_fin_done", 64'(t_dn),  64'd1);
        chk("to_fin_err",  64'(t_eo),  64'd1);
        chk("to_fin_req",  64'(t_req), 64'd0);
        chk("to_fin_blk",  64'(t_blk), 64'd0);
        tick();
        ack_t = 1'b1;
        tick();
        ack_t = 1'b0;
        chk("to_late_done", 64'(t_dn),  64'd0);
        chk("to_late_req",  64'(t_req), 64'd0);

        // Ack on the same edge the timeout would fire: ack wins.
        valid_t = 1'b1; MemWr_in = 1'b1;
        tick();
        valid_t = 1'b0; MemWr_in = 1'b0;
        tick(); tick(); tick();
        chk("race_req", 64'(t_req), 64'd1);
        ack_t = 1'b1;
        tick();
        ack_t = 1'b0;
        chk("race_done", 64'(t_dn), 64'd1);
        chk("race_err",  64'(t_eo), 64'd0);
        tick();

        // Asynchronous reset in the middle of BUSY.
        issue(3'b011, 64'h200, D);
        chk("ar_req_pre", 64'(req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req",   64'(req),   64'd0);
        chk("ar_blk",   64'(blk),   64'd0);
        chk("ar_done",  64'(dn),    64'd0);
        chk("ar_err",   64'(eo),    64'd0);
        chk("ar_addr",  maddr,      64'd0);
        chk("ar_wdata", wdata,      64'd0);
        chk("ar_mask",  64'(wmask), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("ar_after", 64'(req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
